sha256_msg_padder: RTL and testbench
====================================

// Module: sha256_msg_padder
// PURPOSE
//  Upstream stage of sha256_core_v3. Accepts a message as a byte stream and
//  emits FIPS 180-4 padded 512-bit blocks (0x80 marker, zero fill, 64-bit
//  big-endian bit length). Flags each block as first/last so the controller
//  can drive the core's first_run and take hash_out after the last block.
// PARAMETERS
//  LEN_W  64  width of message bit-length counter (bits; length field is 64b)
// PORTS
//  clk          in   1    clock, all logic on rising edge
//  rst          in   1    synchronous active-high reset
//  in_valid     in   1    in_data/in_last valid
//  in_data      in   8    message byte
//  in_last      in   1    marks final byte of message (messages are >=1 byte)
//  in_ready     out  1    byte accepted when in_valid & in_ready
//  blk_valid    out  1    blk_data valid; held until blk_ready
//  blk_ready    in   1    consumer takes block when blk_valid & blk_ready
//  blk_data     out  512  block; first byte in [511:504] (core big-endian order)
//  blk_first    out  1    block is first of its message (-> core first_run)
//  blk_last     out  1    block is final block of its message
// BEHAVIOUR
//  - Interface: one clock; reset is synchronous and active-high.
//  - Reset: state=FILL, byte index=0, bit length=0, first flag=1;
//    in_ready=1, blk_valid=0, blk_first=0, blk_last=0, blk_data=0.
//  - States: FILL, SEND, SEND_EXTRA.
//  - FILL: in_ready=1. Each accepted byte written at index n (0..63), n++,
//    bit length += 8 (wraps mod 2^LEN_W). Transitions:
//      byte 64 accepted, not last        -> SEND (data block, blk_last=0)
//      last accepted, total n<=55        -> SEND, 0x80 at byte n, zero fill,
//                                           length in bytes 56..63, blk_last=1
//      last accepted, 56<=n<=63          -> SEND, 0x80 at byte n, zero fill,
//                                           blk_last=0; extra block pending
//      last accepted, n==64              -> SEND, pure data, blk_last=0;
//                                           extra block pending with 0x80@0
//    (n counts bytes in current block incl. the last byte.)
//  - SEND: in_ready=0, blk_valid=1; blk_data/flags stable until handshake.
//    On blk_ready: extra pending -> SEND_EXTRA; message done -> FILL with
//    n=0, length=0, first=1; else (mid-message) -> FILL with n=0, first=0.
//  - SEND_EXTRA: blk_valid=1, blk_data = zeros (0x80 at byte 0 iff message
//    ended on 64-byte boundary) + length in bytes 56..63, blk_first=0,
//    blk_last=1. On blk_ready -> FILL, counters cleared, first=1.
//  - blk_valid rises the cycle after the completing byte handshake (1-cycle
//    latency); blk_first=1 only on a message's first block.
//  - Length field = bit length including the last byte, zero-extended to 64.
//  - in_ready is low in SEND/SEND_EXTRA; no byte/block handshake overlap.
//  - blk_ready ignored while blk_valid=0. in_last without in_valid ignored.
//  - Reset mid-operation: partial message discarded; outputs at reset values
//    the cycle after rst sampled high.
//  - Stale buffer bytes beyond padding position always output as zero.
// TESTING
//  "abc" (61 62 63, last on 63) -> 1 block: 61626380 00..00 00000000_00000018,
//    first=1,last=1; with core first_run=1 hash ba7816bf...f20015ad.
//  55 bytes 0x00..0x36 -> 1 block, byte55=0x80, length 0x1B8, first=last=1.
//  56 bytes -> block1 byte56=0x80 rest 0, first=1,last=0; block2 all zero
//    + length 0x1C0, first=0,last=1.
//  64 bytes -> block1 pure data last=0; block2 0x80 at byte0, length 0x200.
//  Backpressure: hold blk_ready=0 10 cycles -> blk_data/flags stable,
//    in_ready=0; release -> one handshake, in_ready=1 next cycle.
//  Reset mid-message after 30 bytes, then "abc" -> identical to case 1.

Source files
------------

// File: rtl/sha256_msg_padder.sv
// Byte-stream to SHA-256 block padder: packs message bytes into 512-bit blocks
// and appends the 0x80 marker, zero fill and 64-bit big-endian bit length.
module sha256_msg_padder #(
  parameter int LEN_W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [7:0]   in_data,
  input  logic         in_last,
  output logic         in_ready,
  output logic         blk_valid,
  input  logic         blk_ready,
  output logic [511:0] blk_data,
  output logic         blk_first,
  output logic         blk_last
);

  typedef enum logic [1:0] {FILL, SEND, SEND_EXTRA} state_t;

  state_t             state_q, state_d;
  logic [5:0]         idx_q, idx_d;
  logic [LEN_W-1:0]   len_q, len_d, lenInc;
  logic               first_q, first_d;
  logic               lastBlk_q, lastBlk_d;
  logic               extra_q, extra_d;
  logic               marker_q, marker_d;
  logic               msgDone_q, msgDone_d;
  logic [511:0]       blk_q, blk_d;

  assign lenInc = len_q + LEN_W'(8);

  // Byte i of the block lives at bits [8*(63-i) +: 8]; the buffer is cleared
  // after every block handshake so unused positions always read as zero.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    len_d     = len_q;
    first_d   = first_q;
    lastBlk_d = lastBlk_q;
    extra_d   = extra_q;
    marker_d  = marker_q;
    msgDone_d = msgDone_q;
    blk_d     = blk_q;
    case (state_q)
      FILL: begin
        if (in_valid) begin
          len_d = lenInc;
          idx_d = idx_q + 6'd1;
          for (int i = 0; i < 64; i++) begin
            if (i == int'(idx_q)) blk_d[8*(63-i) +: 8] = in_data;
          end
          if (in_last) begin
            state_d   = SEND;
            msgDone_d = 1'b1;
            idx_d     = '0;
            for (int i = 0; i < 64; i++) begin
              if (i == int'(idx_q) + 1) blk_d[8*(63-i) +: 8] = 8'h80;
            end
            if (idx_q <= 6'd54) begin
              blk_d[63:0] = 64'(lenInc);
              lastBlk_d   = 1'b1;
              extra_d     = 1'b0;
            end else begin
              // No room for the length field: it goes into an extra block.
              lastBlk_d = 1'b0;
              extra_d   = 1'b1;
              marker_d  = (idx_q == 6'd63);
            end
          end else if (idx_q == 6'd63) begin
            state_d   = SEND;
            lastBlk_d = 1'b0;
            extra_d   = 1'b0;
            msgDone_d = 1'b0;
          end
        end
      end
      SEND: begin
        if (blk_ready) begin
          blk_d = '0;
          idx_d = '0;
          if (extra_q) begin
            state_d        = SEND_EXTRA;
            blk_d[511:504] = marker_q ? 8'h80 : 8'h00;
            blk_d[63:0]    = 64'(len_q);
          end else if (msgDone_q) begin
            state_d   = FILL;
            len_d     = '0;
            first_d   = 1'b1;
            msgDone_d = 1'b0;
          end else begin
            state_d = FILL;
            first_d = 1'b0;
          end
        end
      end
      SEND_EXTRA: begin
        if (blk_ready) begin
          state_d   = FILL;
          blk_d     = '0;
          idx_d     = '0;
          len_d     = '0;
          first_d   = 1'b1;
          extra_d   = 1'b0;
          marker_d  = 1'b0;
          msgDone_d = 1'b0;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FILL;
      idx_q     <= '0;
      len_q     <= '0;
      first_q   <= 1'b1;
      lastBlk_q <= 1'b0;
      extra_q   <= 1'b0;
      marker_q  <= 1'b0;
      msgDone_q <= 1'b0;
      blk_q     <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      len_q     <= len_d;
      first_q   <= first_d;
      lastBlk_q <= lastBlk_d;
      extra_q   <= extra_d;
      marker_q  <= marker_d;
      msgDone_q <= msgDone_d;
      blk_q     <= blk_d;
    end
  end

  assign in_ready  = (state_q == FILL);
  assign blk_valid = (state_q != FILL);
  assign blk_data  = blk_valid ? blk_q : '0;
  assign blk_first = (state_q == SEND) && first_q;
  assign blk_last  = ((state_q == SEND) && lastBlk_q) || (state_q == SEND_EXTRA);

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Self-checking bench for sha256_msg_padder: directed cases plus random
// messages compared against a byte-level FIPS 180-4 padding model.
module tb_sha256_msg_padder;

  logic         clk;
  logic         rst;
  logic         inValid;
  logic [7:0]   inData;
  logic         inLast;
  logic         inReady;
  logic         blkValid;
  logic         blkReady;
  logic [511:0] blkData;
  logic         blkFirst;
  logic         blkLast;

  int total = 0;
  int bad   = 0;

  logic [511:0] abcBlk;

  sha256_msg_padder #(.LEN_W(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (inValid),
    .in_data   (inData),
    .in_last   (inLast),
    .in_ready  (inReady),
    .blk_valid (blkValid),
    .blk_ready (blkReady),
    .blk_data  (blkData),
    .blk_first (blkFirst),
    .blk_last  (blkLast)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Reference padding: message, 0x80, zeros to 56 mod 64, then 64-bit bit length.
  task automatic buildBlocks(input logic [7:0] msg[$], output logic [511:0] blks[$]);
    logic [7:0]   p[$];
    logic [63:0]  bits;
    logic [511:0] b;
    p = msg;
    p.push_back(8'h80);
    while ((p.size() % 64) != 56) p.push_back(8'h00);
    bits = 64'(msg.size()) * 64'd8;
    for (int k = 7; k >= 0; k--) p.push_back(bits[8*k +: 8]);
    blks.delete();
    for (int n = 0; n < p.size() / 64; n++) begin
      b = '0;
      for (int i = 0; i < 64; i++) b[8*(63-i) +: 8] = p[64*n + i];
      blks.push_back(b);
    end
  endtask

  task automatic checkResetState(input string tag);
    checkBit({tag, " inReady"}, inReady, 1'b1);
    checkBit({tag, " blkValid"}, blkValid, 1'b0);
    checkBit({tag, " blkFirst"}, blkFirst, 1'b0);
    checkBit({tag, " blkLast"}, blkLast, 1'b0);
    checkOutput({tag, " blkData"}, blkData, '0);
  endtask

  // Random valid/ready traffic for one message; checks every visible block cycle.
  task automatic applyStimulus(input string name, input logic [7:0] msg[$], input int validPct, input int readyPct);
    logic [511:0] exp[$];
    int  sent = 0;
    int  got = 0;
    int  cycles = 0;
    bit  expectBlk = 0;
    bit  expectIn = 0;
    buildBlocks(msg, exp);
    while (got < exp.size() && cycles < 20000) begin
      @(negedge clk);
      cycles++;
      if (expectBlk) checkBit({name, " latency"}, blkValid, 1'b1);
      if (expectIn) begin
        checkBit({name, " inReadyAfterBlk"}, inReady, 1'b1);
        checkBit({name, " idleAfterBlk"}, blkValid, 1'b0);
      end
      expectBlk = 0;
      expectIn  = 0;
      if (blkValid) begin
        checkOutput({name, " data"}, blkData, exp[got]);
        checkBit({name, " first"}, blkFirst, got == 0);
        checkBit({name, " last"}, blkLast, got == exp.size() - 1);
        checkBit({name, " inReadyLow"}, inReady, 1'b0);
      end
      inValid  = (sent < msg.size()) && (int'($urandom_range(99)) < validPct);
      inData   = inValid ? msg[sent] : 8'($urandom);
      inLast   = inValid ? (sent == msg.size() - 1) : 1'($urandom);
      blkReady = int'($urandom_range(99)) < readyPct;
      if (inValid && inReady) begin
        sent++;
        if (sent == msg.size() || (sent % 64) == 0) expectBlk = 1;
      end
      if (blkValid && blkReady) begin
        got++;
        if (got < exp.size() && sent == msg.size()) expectBlk = 1;
        else expectIn = 1;
      end
    end
    checkOutput({name, " blockCount"}, 512'(got), 512'(exp.size()));
    @(negedge clk);
    inValid  = 1'b0;
    inLast   = 1'b0;
    blkReady = 1'b0;
    if (got == exp.size()) begin
      checkBit({name, " endInReady"}, inReady, 1'b1);
      checkBit({name, " endBlkValid"}, blkValid, 1'b0);
    end
  endtask

  // "abc" against the known padded block, holding off blk_ready for hold cycles.
  task automatic runAbcDirected(input string name, input int hold);
    logic [7:0] abc [3];
    abc[0] = 8'h61; abc[1] = 8'h62; abc[2] = 8'h63;
    blkReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkBit({name, " inReady"}, inReady, 1'b1);
      inValid = 1'b1;
      inData  = abc[i];
      inLast  = (i == 2);
    end
    @(negedge clk);
    inValid = 1'b0;
    inLast  = 1'b0;
    checkBit({name, " valid"}, blkValid, 1'b1);
    checkOutput({name, " data"}, blkData, abcBlk);
    checkBit({name, " first"}, blkFirst, 1'b1);
    checkBit({name, " last"}, blkLast, 1'b1);
    for (int c = 0; c < hold; c++) begin
      @(negedge clk);
      checkBit({name, " holdValid"}, blkValid, 1'b1);
      checkOutput({name, " holdData"}, blkData, abcBlk);
      checkBit({name, " holdFirst"}, blkFirst, 1'b1);
      checkBit({name, " holdLast"}, blkLast, 1'b1);
      checkBit({name, " holdInReady"}, inReady, 1'b0);
    end
    blkReady = 1'b1;
    @(negedge clk);
    blkReady = 1'b0;
    checkBit({name, " releaseInReady"}, inReady, 1'b1);
    checkBit({name, " releaseValid"}, blkValid, 1'b0);
  endtask

  initial begin
    logic [7:0] msg[$];
    abcBlk   = {32'h61626380, 416'h0, 64'h18};
    rst      = 1'b1;
    inValid  = 1'b0;
    inData   = 8'h00;
    inLast   = 1'b0;
    blkReady = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkResetState("reset");
    rst = 1'b0;

    runAbcDirected("abcBackpressure", 10);

    foreach (msg[i]) msg.delete();
    msg.delete();
    for (int i = 0; i < 55; i++) msg.push_back(8'(i));
    applyStimulus("len55", msg, 100, 100);

    msg.delete();
    for (int i = 0; i < 56; i++) msg.push_back(8'(i));
    applyStimulus("len56", msg, 100, 100);

    msg.delete();
    for (int i = 0; i < 64; i++) msg.push_back(8'($urandom));
    applyStimulus("len64", msg, 100, 100);

    msg.delete();
    for (int i = 0; i < 63; i++) msg.push_back(8'($urandom));
    applyStimulus("len63", msg, 70, 60);

    msg.delete();
    for (int i = 0; i < 128; i++) msg.push_back(8'($urandom));
    applyStimulus("len128", msg, 80, 50);

    msg.delete();
    msg.push_back(8'($urandom));
    applyStimulus("len1", msg, 100, 40);

    for (int r = 0; r < 12; r++) begin
      int len;
      len = int'($urandom_range(200, 1));
      msg.delete();
      for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
      applyStimulus($sformatf("rand%0d_len%0d", r, len), msg, int'($urandom_range(100, 40)), int'($urandom_range(100, 30)));
    end

    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      inValid = 1'b1;
      inData  = 8'($urandom);
      inLast  = 1'b0;
    end
    @(negedge clk);
    inValid = 1'b0;
    rst     = 1'b1;
    @(negedge clk);
    checkResetState("midReset");
    rst = 1'b0;
    runAbcDirected("abcAfterReset", 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
